// File: rtl/udp_frame_pkg.sv
// Shared constants for the UDP frame source: frame byte map, IP header words and FSM states.
// No logic; latency and backpressure live in the modules that import this package.
package udp_frame_pkg;

  localparam logic [6:0] PREAMBLE_END = 7'h07;
  localparam logic [6:0] IPID_ADDR    = 7'h1A;
  localparam logic [6:0] CSUM_ADDR    = 7'h20;
  localparam logic [6:0] PAYLOAD_BASE = 7'h32;
  localparam logic [4:0] PAYLOAD_LEN  = 5'd18;
  localparam logic [6:0] FRAME_END    = 7'h44;

  localparam logic [15:0] HDR_VER_TOS   = 16'h4500;
  localparam logic [15:0] HDR_TOT_LEN   = 16'h002E;
  localparam logic [15:0] HDR_TTL_PROTO = 16'h8011;

  // Nine 16-bit words go into the IP header sum.
  localparam logic [3:0] CSUM_LAST = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_FOLD,
    ST_START,
    ST_WAIT_BUSY,
    ST_SENDING
  } state_t;

endpackage

// File: rtl/udp_payload_pingpong.sv
// Two 18-byte payload banks: writes go to bank fill_sel, reads come from the other bank.
// Read data is registered (one cycle); no backpressure, writes beyond index 17 are dropped.
module udp_payload_pingpong
  import udp_frame_pkg::*;
(
  input  logic       clk20,
  input  logic       fill_sel,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_data
);

  logic [7:0] mem [2][PAYLOAD_LEN];

  always_ff @(posedge clk20) begin
    if (wr_en && (wr_addr < PAYLOAD_LEN)) begin
      mem[fill_sel][wr_addr] <= wr_data;
    end
    if (rd_en && (rd_idx < PAYLOAD_LEN)) begin
      rd_data <= mem[~fill_sel][rd_idx];
    end
  end

endmodule

// File: rtl/udp_frame_source.sv
// Supplies the complete UDP frame byte stream to the 10BASE-T transmitter; pkt_data is one cycle after rdaddress.
// commit is taken only in IDLE (commit_ready) and never queued; start_tx follows an accepted commit by 11 cycles.
module udp_frame_source
  import udp_frame_pkg::*;
#(
  parameter logic [31:0] IP_SRC   = 32'hC0A8002C,
  parameter logic [31:0] IP_DST   = 32'hC0A80140,
  parameter logic [47:0] MAC_DST  = 48'h00248C88DDC0,
  parameter logic [47:0] MAC_SRC  = 48'h001234567890,
  parameter logic [15:0] UDP_PORT = 16'h0400
) (
  input  logic       clk20,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       commit_ready,
  output logic       start_tx,
  input  logic       tx_busy,
  input  logic [6:0] rdaddress,
  output logic [7:0] pkt_data
);

  state_t       state, state_nxt;
  logic         commit_acc;
  logic         fill_sel;
  logic [15:0]  ip_id;
  logic [15:0]  csum_reg;
  logic [15:0]  csum_word;
  logic [19:0]  acc;
  logic [3:0]   csum_cnt;
  logic [16:0]  fold_t;
  logic [15:0]  fold_s;
  logic [399:0] hdr_vec;
  logic [7:0]   hdr_byte;
  logic [7:0]   hdr_q;
  logic [7:0]   pay_byte;
  logic         pay_sel_q;
  logic         in_payload;
  logic [4:0]   pay_idx;

  assign in_payload = (rdaddress >= PAYLOAD_BASE) && (rdaddress < FRAME_END);
  assign pay_idx    = 5'(rdaddress - PAYLOAD_BASE);

  udp_payload_pingpong u_payload (
    .clk20   (clk20),
    .fill_sel(fill_sel),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (in_payload),
    .rd_idx  (pay_idx),
    .rd_data (pay_byte)
  );

  always_ff @(posedge clk20) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    commit_ready = 1'b0;
    commit_acc   = 1'b0;
    case (state)
      ST_IDLE: begin
        commit_ready = 1'b1;
        if (commit) begin
          commit_acc = 1'b1;
          state_nxt  = ST_CSUM;
        end
      end
      ST_CSUM:      if (csum_cnt == CSUM_LAST) state_nxt = ST_FOLD;
      ST_FOLD:      state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy) state_nxt = ST_SENDING;
      ST_SENDING:   if (!tx_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    csum_word = 16'h0000;
    case (csum_cnt)
      4'd0: csum_word = HDR_VER_TOS;
      4'd1: csum_word = HDR_TOT_LEN;
      4'd2: csum_word = ip_id;
      4'd4: csum_word = HDR_TTL_PROTO;
      4'd5: csum_word = IP_SRC[31:16];
      4'd6: csum_word = IP_SRC[15:0];
      4'd7: csum_word = IP_DST[31:16];
      4'd8: csum_word = IP_DST[15:0];
      default: csum_word = 16'h0000;
    endcase
    fold_t = {1'b0, acc[15:0]} + {13'h0000, acc[19:16]};
    fold_s = fold_t[15:0] + {15'h0000, fold_t[16]};
  end

  // Header bytes 00..31 laid out MSB-first; bytes 44..7F read as zero.
  always_comb begin
    hdr_vec = {{7{8'h55}}, 8'hD5, MAC_DST, MAC_SRC, 16'h0800,
               HDR_VER_TOS, HDR_TOT_LEN, ip_id, 16'h0000, HDR_TTL_PROTO, csum_reg,
               IP_SRC, IP_DST, UDP_PORT, UDP_PORT, 16'h001A, 16'h0000};
    hdr_byte = 8'h00;
    for (int i = 0; i < int'(PAYLOAD_BASE); i++) begin
      if (rdaddress == 7'(i)) hdr_byte = hdr_vec[399 - 8*i -: 8];
    end
  end

  always_ff @(posedge clk20) begin
    if (!rst_n) begin
      fill_sel  <= 1'b0;
      ip_id     <= 16'h0000;
      csum_reg  <= 16'h0000;
      acc       <= 20'h00000;
      csum_cnt  <= 4'd0;
      start_tx  <= 1'b0;
      hdr_q     <= 8'h00;
      pay_sel_q <= 1'b0;
    end else begin
      start_tx  <= (state == ST_START);
      hdr_q     <= hdr_byte;
      pay_sel_q <= in_payload;
      if (commit_acc) begin
        fill_sel <= ~fill_sel;
        acc      <= 20'h00000;
        csum_cnt <= 4'd0;
      end else if (state == ST_CSUM) begin
        acc      <= acc + {4'h0, csum_word};
        csum_cnt <= csum_cnt + 4'd1;
      end
      if (state == ST_FOLD) csum_reg <= ~fold_s;
      if ((state == ST_SENDING) && !tx_busy) ip_id <= ip_id + 16'd1;
    end
  end

  assign pkt_data = pay_sel_q ? pay_byte : hdr_q;

endmodule

// File: tb/tb_udp_frame_source.sv
// Bench for udp_frame_source: randomized payloads and transmitter timing against a frame-level model.
module tb_udp_frame_source;

  localparam logic [31:0] IP_SRC   = 32'hC0A8002C;
  localparam logic [31:0] IP_DST   = 32'hC0A80140;
  localparam logic [47:0] MAC_DST  = 48'h00248C88DDC0;
  localparam logic [47:0] MAC_SRC  = 48'h001234567890;
  localparam logic [15:0] UDP_PORT = 16'h0400;

  logic       clk20 = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'h00;
  logic       commit = 1'b0;
  logic       tx_busy = 1'b0;
  logic [6:0] rdaddress = 7'd0;
  logic       commit_ready;
  logic       start_tx;
  logic [7:0] pkt_data;

  int checks = 0;
  int failures = 0;

  // Model state: fill bank, next IP id, bank contents and which bytes are known.
  int          m_fill = 0;
  logic [15:0] m_id = 16'h0000;
  logic [7:0]  m_bank [2][18];
  bit          m_known [2][18];

  udp_frame_source dut (
    .clk20       (clk20),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_ready(commit_ready),
    .start_tx    (start_tx),
    .tx_busy     (tx_busy),
    .rdaddress   (rdaddress),
    .pkt_data    (pkt_data)
  );

  always #25 clk20 = ~clk20;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic bit exp_byte(input int a, output logic [7:0] v);
    logic [15:0] hw [25];
    logic [47:0] md, ms;
    logic [31:0] is, id;
    int unsigned s;
    logic [15:0] ck;
    int tx;
    md = MAC_DST; ms = MAC_SRC; is = IP_SRC; id = IP_DST;
    s = 32'h4500 + 32'h002E + {16'h0, m_id} + 32'h8011 + {16'h0, is[31:16]} + {16'h0, is[15:0]}
        + {16'h0, id[31:16]} + {16'h0, id[15:0]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~s[15:0];
    hw = '{16'h5555, 16'h5555, 16'h5555, 16'h55D5,
           md[47:32], md[31:16], md[15:0], ms[47:32], ms[31:16], ms[15:0],
           16'h0800, 16'h4500, 16'h002E, m_id, 16'h0000, 16'h8011, ck,
           is[31:16], is[15:0], id[31:16], id[15:0],
           UDP_PORT, UDP_PORT, 16'h001A, 16'h0000};
    tx = m_fill ^ 1;
    v = 8'h00;
    if (a < 50) begin
      v = (a % 2 == 0) ? hw[a/2][15:8] : hw[a/2][7:0];
      return 1'b1;
    end else if (a < 68) begin
      v = m_bank[tx][a-50];
      return m_known[tx][a-50];
    end
    return 1'b1;
  endfunction

  task automatic read_at(input logic [6:0] a, output logic [7:0] v);
    rdaddress = a;
    @(negedge clk20);
    v = pkt_data;
  endtask

  task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk20);
    wr_en = 1'b0;
    if (a < 5'd18) begin
      m_bank[m_fill][a] = d;
      m_known[m_fill][a] = 1'b1;
    end
  endtask

  task automatic fill_bank(input bit rnd);
    for (int i = 0; i < 18; i++) write_byte(5'(i), rnd ? 8'($urandom) : 8'(i));
    // Out-of-range indices must not disturb the bank.
    for (int i = 0; i < 2; i++) write_byte(5'($urandom_range(18, 31)), 8'($urandom));
  endtask

  task automatic sweep_frame(output int bad, output int fa, output logic [7:0] got, output logic [7:0] want);
    logic [7:0] v, e;
    bad = 0; fa = -1; got = 8'h00; want = 8'h00;
    for (int a = 0; a < 128; a++) begin
      read_at(7'(a), v);
      if (exp_byte(a, e) && (v !== e)) begin
        if (bad == 0) begin fa = a; got = v; want = e; end
        bad++;
      end
    end
  endtask

  // Commit (optionally with a same-cycle write); report the cycle offset of start_tx and pulse count.
  task automatic do_commit(input bit wr, input logic [4:0] wa, input logic [7:0] wd,
                           output int start_at, output int pulses);
    commit = 1'b1;
    if (wr) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    @(negedge clk20);
    commit = 1'b0; wr_en = 1'b0;
    if (wr && wa < 5'd18) begin m_bank[m_fill][wa] = wd; m_known[m_fill][wa] = 1'b1; end
    m_fill ^= 1;
    start_at = -1; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (start_tx === 1'b1) begin
        pulses++;
        if (start_at < 0) start_at = i;
      end
      @(negedge clk20);
    end
  endtask

  task automatic run_send(input bit write_aa, output int bad, output int fa,
                          output logic [7:0] got, output logic [7:0] want);
    int b2, fa2;
    logic [7:0] g2, w2;
    repeat ($urandom_range(0, 3)) @(negedge clk20);
    tx_busy = 1'b1;
    @(negedge clk20);
    sweep_frame(bad, fa, got, want);
    if (write_aa) begin
      for (int i = 0; i < 18; i++) write_byte(5'(i), 8'hAA);
      sweep_frame(b2, fa2, g2, w2);
      if (bad == 0 && b2 != 0) begin fa = fa2; got = g2; want = w2; end
      bad += b2;
    end
    tx_busy = 1'b0;
    @(negedge clk20);
    m_id = m_id + 16'd1;
  endtask

  task automatic model_reset();
    m_fill = 0; m_id = 16'h0000;
    foreach (m_known[b, i]) m_known[b][i] = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk20);
    model_reset();
    checks++; if (commit_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", commit_ready); end
    checks++; if (start_tx !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", start_tx); end
    checks++; if (pkt_data !== 8'h00) begin failures++; $display("FAIL reset_pkt got=%h want=00", pkt_data); end
    rst_n = 1'b1;
    read_at(7'h1B, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_ipid got=%h want=00", v); end
    read_at(7'h21, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_csum got=%h want=00", v); end
    read_at(7'h07, v);
    checks++; if (v !== 8'hD5) begin failures++; $display("FAIL reset_sfd got=%h want=D5", v); end
  endtask

  task automatic test_first_frame();
    int sa, p, bad, fa;
    logic [7:0] v, g, w;
    fill_bank(1'b0);
    do_commit(1'b0, 5'd0, 8'h00, sa, p);
    checks++; if (sa !== 11 || p !== 1) begin failures++; $display("FAIL first_start_timing at=%0d pulses=%0d want at=11 pulses=1", sa, p); end
    read_at(7'h1A, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL first_ipid_hi got=%h want=00", v); end
    read_at(7'h1B, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL first_ipid_lo got=%h want=00", v); end
    read_at(7'h20, v); checks++; if (v !== 8'hB8) begin failures++; $display("FAIL first_csum_hi got=%h want=B8", v); end
    read_at(7'h21, v); checks++; if (v !== 8'h02) begin failures++; $display("FAIL first_csum_lo got=%h want=02", v); end
    read_at(7'h43, v); checks++; if (v !== 8'h11) begin failures++; $display("FAIL first_last_payload got=%h want=11", v); end
    run_send(1'b1, bad, fa, g, w);
    checks++; if (bad !== 0) begin failures++; $display("FAIL first_frame_bytes bad=%0d addr=%h got=%h want=%h", bad, fa, g, w); end
  endtask

  task automatic test_second_frame();
    int sa, p, bad, fa, not_aa;
    logic [7:0] v, g, w;
    do_commit(1'b0, 5'd0, 8'h00, sa, p);
    checks++; if (sa !== 11 || p !== 1) begin failures++; $display("FAIL second_start_timing at=%0d pulses=%0d want at=11 pulses=1", sa, p); end
    read_at(7'h1A, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL second_ipid_hi got=%h want=00", v); end
    read_at(7'h1B, v); checks++; if (v !== 8'h01) begin failures++; $display("FAIL second_ipid_lo got=%h want=01", v); end
    read_at(7'h20, v); checks++; if (v !== 8'hB8) begin failures++; $display("FAIL second_csum_hi got=%h want=B8", v); end
    read_at(7'h21, v); checks++; if (v !== 8'h01) begin failures++; $display("FAIL second_csum_lo got=%h want=01", v); end
    not_aa = 0;
    for (int a = 8'h32; a <= 8'h43; a++) begin
      read_at(7'(a), v);
      if (v !== 8'hAA) not_aa++;
    end
    checks++; if (not_aa !== 0) begin failures++; $display("FAIL second_payload_aa bytes_wrong=%0d want=0", not_aa); end
    run_send(1'b0, bad, fa, g, w);
    checks++; if (bad !== 0) begin failures++; $display("FAIL second_frame_bytes bad=%0d addr=%h got=%h want=%h", bad, fa, g, w); end
  endtask

  task automatic test_held_commit();
    int starts, bad, fa;
    bit ready_bad;
    logic [7:0] g, w;
    fill_bank(1'b1);
    commit = 1'b1;
    @(negedge clk20);
    m_fill ^= 1;
    starts = 0; ready_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_tx === 1'b1) starts++;
      if (commit_ready !== 1'b0) ready_bad = 1'b1;
      @(negedge clk20);
    end
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (start_tx === 1'b1) starts++;
      if (commit_ready !== 1'b0) ready_bad = 1'b1;
      @(negedge clk20);
    end
    tx_busy = 1'b0;
    @(negedge clk20);
    m_id = m_id + 16'd1;
    checks++; if (commit_ready !== 1'b1) begin failures++; $display("FAIL held_idle_ready got=%b want=1", commit_ready); end
    @(negedge clk20);
    m_fill ^= 1;
    checks++; if (commit_ready !== 1'b0) begin failures++; $display("FAIL held_reaccept got=%b want=0", commit_ready); end
    commit = 1'b0;
    checks++; if (starts !== 1) begin failures++; $display("FAIL held_one_start got=%0d want=1", starts); end
    checks++; if (ready_bad !== 1'b0) begin failures++; $display("FAIL held_ready_low got=%b want=0", ready_bad); end
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      if (start_tx === 1'b1) starts++;
      @(negedge clk20);
    end
    checks++; if (starts !== 1) begin failures++; $display("FAIL held_second_start got=%0d want=1", starts); end
    run_send(1'b0, bad, fa, g, w);
    checks++; if (bad !== 0) begin failures++; $display("FAIL held_frame_bytes bad=%0d addr=%h got=%h want=%h", bad, fa, g, w); end
  endtask

  task automatic test_ignored_commit();
    int sa, p, bad, fa, starts;
    bit ready_bad;
    logic [7:0] g, w;
    fill_bank(1'b1);
    do_commit(1'b0, 5'd0, 8'h00, sa, p);
    checks++; if (sa !== 11) begin failures++; $display("FAIL ignored_start_timing got=%0d want=11", sa); end
    commit = 1'b1;
    @(negedge clk20);
    commit = 1'b0;
    run_send(1'b0, bad, fa, g, w);
    checks++; if (bad !== 0) begin failures++; $display("FAIL ignored_frame_bytes bad=%0d addr=%h got=%h want=%h", bad, fa, g, w); end
    starts = 0; ready_bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (start_tx === 1'b1) starts++;
      if (commit_ready !== 1'b1) ready_bad = 1'b1;
      @(negedge clk20);
    end
    checks++; if (starts !== 0 || ready_bad !== 1'b0) begin failures++; $display("FAIL ignored_not_queued starts=%0d ready_bad=%b want 0/0", starts, ready_bad); end
  endtask

  task automatic test_write_with_commit();
    int sa, p, bad, fa;
    logic [7:0] v, g, w;
    fill_bank(1'b1);
    do_commit(1'b1, 5'd5, 8'h5A, sa, p);
    checks++; if (sa !== 11) begin failures++; $display("FAIL wrcommit_start_timing got=%0d want=11", sa); end
    read_at(7'h37, v);
    checks++; if (v !== 8'h5A) begin failures++; $display("FAIL wrcommit_byte got=%h want=5A", v); end
    run_send(1'b0, bad, fa, g, w);
    checks++; if (bad !== 0) begin failures++; $display("FAIL wrcommit_frame_bytes bad=%0d addr=%h got=%h want=%h", bad, fa, g, w); end
  endtask

  task automatic test_id_wrap();
    int sa, p, bad, fa;
    logic [7:0] v, g, w;
    force dut.ip_id = 16'hFFFF;
    @(negedge clk20);
    release dut.ip_id;
    m_id = 16'hFFFF;
    fill_bank(1'b1);
    do_commit(1'b0, 5'd0, 8'h00, sa, p);
    read_at(7'h1A, v); checks++; if (v !== 8'hFF) begin failures++; $display("FAIL wrap_ipid_ffff got=%h want=FF", v); end
    read_at(7'h20, v); checks++; if (v !== 8'hB8) begin failures++; $display("FAIL wrap_csum_hi got=%h want=B8", v); end
    read_at(7'h21, v); checks++; if (v !== 8'h02) begin failures++; $display("FAIL wrap_csum_lo got=%h want=02", v); end
    run_send(1'b0, bad, fa, g, w);
    checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_frame_bytes bad=%0d addr=%h got=%h want=%h", bad, fa, g, w); end
    fill_bank(1'b1);
    do_commit(1'b0, 5'd0, 8'h00, sa, p);
    read_at(7'h1A, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL wrap_ipid_hi got=%h want=00", v); end
    read_at(7'h1B, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL wrap_ipid_lo got=%h want=00", v); end
    run_send(1'b0, bad, fa, g, w);
  endtask

  task automatic test_reset_mid_frame();
    int sa, p, bad, fa;
    logic [7:0] v, g, w;
    fill_bank(1'b1);
    do_commit(1'b0, 5'd0, 8'h00, sa, p);
    tx_busy = 1'b1;
    rdaddress = 7'h07;
    repeat (3) @(negedge clk20);
    rst_n = 1'b0;
    @(negedge clk20);
    model_reset();
    checks++; if (start_tx !== 1'b0) begin failures++; $display("FAIL midrst_start got=%b want=0", start_tx); end
    checks++; if (pkt_data !== 8'h00) begin failures++; $display("FAIL midrst_pkt got=%h want=00", pkt_data); end
    checks++; if (commit_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", commit_ready); end
    rst_n = 1'b1;
    tx_busy = 1'b0;
    @(negedge clk20);
    fill_bank(1'b1);
    do_commit(1'b0, 5'd0, 8'h00, sa, p);
    checks++; if (sa !== 11) begin failures++; $display("FAIL midrst_start_timing got=%0d want=11", sa); end
    read_at(7'h1B, v); checks++; if (v !== 8'h00) begin failures++; $display("FAIL midrst_ipid got=%h want=00", v); end
    read_at(7'h21, v); checks++; if (v !== 8'h02) begin failures++; $display("FAIL midrst_csum_lo got=%h want=02", v); end
    run_send(1'b0, bad, fa, g, w);
    checks++; if (bad !== 0) begin failures++; $display("FAIL midrst_frame_bytes bad=%0d addr=%h got=%h want=%h", bad, fa, g, w); end
  endtask

  task automatic test_random_frames();
    int sa, p, bad, fa;
    logic [7:0] g, w;
    for (int n = 0; n < 3; n++) begin
      fill_bank(1'b1);
      repeat ($urandom_range(0, 4)) @(negedge clk20);
      do_commit(1'b0, 5'd0, 8'h00, sa, p);
      checks++; if (sa !== 11 || p !== 1) begin failures++; $display("FAIL rand%0d_start at=%0d pulses=%0d want 11/1", n, sa, p); end
      run_send(1'($urandom_range(0, 1)), bad, fa, g, w);
      checks++; if (bad !== 0) begin failures++; $display("FAIL rand%0d_frame_bytes bad=%0d addr=%h got=%h want=%h", n, bad, fa, g, w); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk20);
    test_reset();
    test_first_frame();
    test_second_frame();
    test_held_commit();
    test_ignored_commit();
    test_write_with_commit();
    test_id_wrap();
    test_reset_mid_frame();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
